// File: rtl/mem_axi_arbiter.sv
// mem_axi_arbiter
//   Shares the single 64-bit AXI slave port into the PS DDR controller
//   between two FPGA-side masters (m0 = Rocket memory port, m1 = host
//   DMA / debug loader).
//
//   AR and AW are arbitrated independently with 1-bit round-robin
//   pointers. A winner is locked while its request is presented but not
//   yet accepted. The W channel is locked to the AW winner until wlast.
//   The outgoing ID is {master_idx, id}, and R/B responses are steered
//   back by that top ID bit.
//
// Ports
//   clk, reset                  host clock, synchronous active-high reset
//   m{0,1}_ar_* / m{0,1}_aw_*   per-master read / write address
//   m{0,1}_w_*                  per-master write data
//   m{0,1}_r_* / m{0,1}_b_*     per-master read / write responses
//   s_ar_* / s_aw_* / s_w_*     slave-side requests (ID is ID_W+1 wide)
//   s_r_* / s_b_*               slave-side responses (ID is ID_W+1 wide)
//
// Optional build macro
//   MEM_ARB_STATS_EN  adds stat_clear input plus four saturating 32-bit
//                     grant counters (stat_rd_grants0/1, stat_wr_grants0/1).
module mem_axi_arbiter #(
  parameter int ID_W   = 5,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic                clk,
  input  logic                reset,
  // master 0 read address
  input  logic                m0_ar_valid,
  output logic                m0_ar_ready,
  input  logic [ADDR_W-1:0]   m0_ar_addr,
  input  logic [ID_W-1:0]     m0_ar_id,
  input  logic [7:0]          m0_ar_len,
  input  logic [2:0]          m0_ar_size,
  input  logic [1:0]          m0_ar_burst,
  // master 1 read address
  input  logic                m1_ar_valid,
  output logic                m1_ar_ready,
  input  logic [ADDR_W-1:0]   m1_ar_addr,
  input  logic [ID_W-1:0]     m1_ar_id,
  input  logic [7:0]          m1_ar_len,
  input  logic [2:0]          m1_ar_size,
  input  logic [1:0]          m1_ar_burst,
  // master 0 write address
  input  logic                m0_aw_valid,
  output logic                m0_aw_ready,
  input  logic [ADDR_W-1:0]   m0_aw_addr,
  input  logic [ID_W-1:0]     m0_aw_id,
  input  logic [7:0]          m0_aw_len,
  input  logic [2:0]          m0_aw_size,
  input  logic [1:0]          m0_aw_burst,
  // master 1 write address
  input  logic                m1_aw_valid,
  output logic                m1_aw_ready,
  input  logic [ADDR_W-1:0]   m1_aw_addr,
  input  logic [ID_W-1:0]     m1_aw_id,
  input  logic [7:0]          m1_aw_len,
  input  logic [2:0]          m1_aw_size,
  input  logic [1:0]          m1_aw_burst,
  // master write data
  input  logic                m0_w_valid,
  output logic                m0_w_ready,
  input  logic [DATA_W-1:0]   m0_w_data,
  input  logic [DATA_W/8-1:0] m0_w_strb,
  input  logic                m0_w_last,
  input  logic                m1_w_valid,
  output logic                m1_w_ready,
  input  logic [DATA_W-1:0]   m1_w_data,
  input  logic [DATA_W/8-1:0] m1_w_strb,
  input  logic                m1_w_last,
  // master read responses
  output logic                m0_r_valid,
  input  logic                m0_r_ready,
  output logic [DATA_W-1:0]   m0_r_data,
  output logic [ID_W-1:0]     m0_r_id,
  output logic [1:0]          m0_r_resp,
  output logic                m0_r_last,
  output logic                m1_r_valid,
  input  logic                m1_r_ready,
  output logic [DATA_W-1:0]   m1_r_data,
  output logic [ID_W-1:0]     m1_r_id,
  output logic [1:0]          m1_r_resp,
  output logic                m1_r_last,
  // master write responses
  output logic                m0_b_valid,
  input  logic                m0_b_ready,
  output logic [ID_W-1:0]     m0_b_id,
  output logic [1:0]          m0_b_resp,
  output logic                m1_b_valid,
  input  logic                m1_b_ready,
  output logic [ID_W-1:0]     m1_b_id,
  output logic [1:0]          m1_b_resp,
  // slave read address
  output logic                s_ar_valid,
  input  logic                s_ar_ready,
  output logic [ADDR_W-1:0]   s_ar_addr,
  output logic [ID_W:0]       s_ar_id,
  output logic [7:0]          s_ar_len,
  output logic [2:0]          s_ar_size,
  output logic [1:0]          s_ar_burst,
  // slave write address
  output logic                s_aw_valid,
  input  logic                s_aw_ready,
  output logic [ADDR_W-1:0]   s_aw_addr,
  output logic [ID_W:0]       s_aw_id,
  output logic [7:0]          s_aw_len,
  output logic [2:0]          s_aw_size,
  output logic [1:0]          s_aw_burst,
  // slave write data
  output logic                s_w_valid,
  input  logic                s_w_ready,
  output logic [DATA_W-1:0]   s_w_data,
  output logic [DATA_W/8-1:0] s_w_strb,
  output logic                s_w_last,
  // slave read response
  input  logic                s_r_valid,
  output logic                s_r_ready,
  input  logic [DATA_W-1:0]   s_r_data,
  input  logic [ID_W:0]       s_r_id,
  input  logic [1:0]          s_r_resp,
  input  logic                s_r_last,
  // slave write response
  input  logic                s_b_valid,
  output logic                s_b_ready,
  input  logic [ID_W:0]       s_b_id,
  input  logic [1:0]          s_b_resp
`ifdef MEM_ARB_STATS_EN
  ,
  input  logic                stat_clear,
  output logic [31:0]         stat_rd_grants0,
  output logic [31:0]         stat_rd_grants1,
  output logic [31:0]         stat_wr_grants0,
  output logic [31:0]         stat_wr_grants1
`endif
);

  typedef enum logic [1:0] {
    W_IDLE  = 2'd0,
    W_DATA0 = 2'd1,
    W_DATA1 = 2'd2
  } w_state_e;

  w_state_e w_state_q, w_state_d;

  logic rr_ar_q, rr_ar_d, ar_lock_q, ar_lock_d, ar_own_q, ar_own_d;
  logic rr_aw_q, rr_aw_d, aw_lock_q, aw_lock_d, aw_own_q, aw_own_d;
  logic ar_win, aw_win, ar_hs, aw_hs, aw_offer, w_hs;

  // ---------------- AR arbitration (combinational, no added latency)
  // A locked grant keeps the owner; otherwise the pointer breaks ties and a
  // lone requester wins regardless of the pointer.
  always_comb begin
    ar_win = 1'b0;
    if (ar_lock_q)                       ar_win = ar_own_q;
    else if (m0_ar_valid && m1_ar_valid) ar_win = rr_ar_q;
    else if (m1_ar_valid)                ar_win = 1'b1;
  end

  assign s_ar_valid  = !reset && (ar_win ? m1_ar_valid : m0_ar_valid);
  assign s_ar_addr   = ar_win ? m1_ar_addr  : m0_ar_addr;
  assign s_ar_id     = {ar_win, (ar_win ? m1_ar_id : m0_ar_id)};
  assign s_ar_len    = ar_win ? m1_ar_len   : m0_ar_len;
  assign s_ar_size   = ar_win ? m1_ar_size  : m0_ar_size;
  assign s_ar_burst  = ar_win ? m1_ar_burst : m0_ar_burst;
  assign m0_ar_ready = !reset && !ar_win && s_ar_ready;
  assign m1_ar_ready = !reset &&  ar_win && s_ar_ready;
  assign ar_hs       = s_ar_valid && s_ar_ready;

  always_comb begin
    rr_ar_d   = ar_hs ? ~ar_win : rr_ar_q;
    ar_lock_d = s_ar_valid && !s_ar_ready;
    ar_own_d  = ar_win;
  end

  // ---------------- AW arbitration (offered only while the write FSM is idle)
  assign aw_offer = (w_state_q == W_IDLE);

  always_comb begin
    aw_win = 1'b0;
    if (aw_lock_q)                       aw_win = aw_own_q;
    else if (m0_aw_valid && m1_aw_valid) aw_win = rr_aw_q;
    else if (m1_aw_valid)                aw_win = 1'b1;
  end

  assign s_aw_valid  = !reset && aw_offer && (aw_win ? m1_aw_valid : m0_aw_valid);
  assign s_aw_addr   = aw_win ? m1_aw_addr  : m0_aw_addr;
  assign s_aw_id     = {aw_win, (aw_win ? m1_aw_id : m0_aw_id)};
  assign s_aw_len    = aw_win ? m1_aw_len   : m0_aw_len;
  assign s_aw_size   = aw_win ? m1_aw_size  : m0_aw_size;
  assign s_aw_burst  = aw_win ? m1_aw_burst : m0_aw_burst;
  assign m0_aw_ready = !reset && aw_offer && !aw_win && s_aw_ready;
  assign m1_aw_ready = !reset && aw_offer &&  aw_win && s_aw_ready;
  assign aw_hs       = s_aw_valid && s_aw_ready;

  always_comb begin
    rr_aw_d   = aw_hs ? ~aw_win : rr_aw_q;
    aw_lock_d = s_aw_valid && !s_aw_ready;
    aw_own_d  = aw_win;
  end

  // ---------------- Write FSM: W is steered to the AW winner until wlast.
  // Beats from either master before their AW grant see ready=0.
  always_comb begin
    w_state_d  = w_state_q;
    s_w_valid  = 1'b0;
    s_w_data   = m0_w_data;
    s_w_strb   = m0_w_strb;
    s_w_last   = m0_w_last;
    m0_w_ready = 1'b0;
    m1_w_ready = 1'b0;
    w_hs       = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs) w_state_d = aw_win ? W_DATA1 : W_DATA0;
      end
      W_DATA0: begin
        s_w_valid  = !reset && m0_w_valid;
        m0_w_ready = !reset && s_w_ready;
        w_hs       = s_w_valid && s_w_ready;
        if (w_hs && m0_w_last) w_state_d = W_IDLE;
      end
      W_DATA1: begin
        s_w_valid  = !reset && m1_w_valid;
        s_w_data   = m1_w_data;
        s_w_strb   = m1_w_strb;
        s_w_last   = m1_w_last;
        m1_w_ready = !reset && s_w_ready;
        w_hs       = s_w_valid && s_w_ready;
        if (w_hs && m1_w_last) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_state_q <= W_IDLE;
      rr_ar_q   <= 1'b0;
      ar_lock_q <= 1'b0;
      ar_own_q  <= 1'b0;
      rr_aw_q   <= 1'b0;
      aw_lock_q <= 1'b0;
      aw_own_q  <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      rr_ar_q   <= rr_ar_d;
      ar_lock_q <= ar_lock_d;
      ar_own_q  <= ar_own_d;
      rr_aw_q   <= rr_aw_d;
      aw_lock_q <= aw_lock_d;
      aw_own_q  <= aw_own_d;
    end
  end

  // ---------------- Response steering by the tag bit (pure combinational)
  assign m0_r_valid = !reset && s_r_valid && !s_r_id[ID_W];
  assign m1_r_valid = !reset && s_r_valid &&  s_r_id[ID_W];
  assign m0_r_data  = s_r_data;
  assign m1_r_data  = s_r_data;
  assign m0_r_id    = s_r_id[ID_W-1:0];
  assign m1_r_id    = s_r_id[ID_W-1:0];
  assign m0_r_resp  = s_r_resp;
  assign m1_r_resp  = s_r_resp;
  assign m0_r_last  = s_r_last;
  assign m1_r_last  = s_r_last;
  assign s_r_ready  = !reset && (s_r_id[ID_W] ? m1_r_ready : m0_r_ready);

  assign m0_b_valid = !reset && s_b_valid && !s_b_id[ID_W];
  assign m1_b_valid = !reset && s_b_valid &&  s_b_id[ID_W];
  assign m0_b_id    = s_b_id[ID_W-1:0];
  assign m1_b_id    = s_b_id[ID_W-1:0];
  assign m0_b_resp  = s_b_resp;
  assign m1_b_resp  = s_b_resp;
  assign s_b_ready  = !reset && (s_b_id[ID_W] ? m1_b_ready : m0_b_ready);

`ifdef MEM_ARB_STATS_EN
  // ---------------- Grant statistics (saturating, clear beats increment)
  logic [31:0] rd0_q, rd1_q, wr0_q, wr1_q;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset || stat_clear) begin
      rd0_q <= '0;
      rd1_q <= '0;
      wr0_q <= '0;
      wr1_q <= '0;
    end else begin
      if (ar_hs && !ar_win) rd0_q <= sat_inc(rd0_q);
      if (ar_hs &&  ar_win) rd1_q <= sat_inc(rd1_q);
      if (aw_hs && !aw_win) wr0_q <= sat_inc(wr0_q);
      if (aw_hs &&  aw_win) wr1_q <= sat_inc(wr1_q);
    end
  end

  assign stat_rd_grants0 = rd0_q;
  assign stat_rd_grants1 = rd1_q;
  assign stat_wr_grants0 = wr0_q;
  assign stat_wr_grants1 = wr1_q;
`endif

endmodule

// File: doc/mem_axi_arbiter.md
Name: mem_axi_arbiter

Overview:
- Shares the single 64-bit AXI slave port into the PS DDR controller between two FPGA-side masters.
- Master 0 is the Rocket memory port; master 1 is a host DMA / debug loader.
- Arbitrates AR and AW independently with round-robin priority, and locks the W channel to the AW winner until wlast.
- Tags the outgoing ID with the master index and steers R/B responses back by that tag bit.
- Sits between the Top memory port and the 0x1000_0000 DDR window remap.

Parameters:
- ID_W, 5: per-master ID width; slave-side ID is ID_W+1.
- ADDR_W, 32: address width.
- DATA_W, 64: data width; strobe width is DATA_W/8.

Ports:
- clk  in  1  host clock (host_clk domain).
- reset  in  1  synchronous, active-high reset.
- m{0,1}_ar_valid/ready/addr/id/len/size/burst  in/out/in/in/in/in/in  1/1/ADDR_W/ID_W/8/3/2  per-master read address.
- m{0,1}_aw_valid/ready/addr/id/len/size/burst  in/out/in/in/in/in/in  1/1/ADDR_W/ID_W/8/3/2  per-master write address.
- m{0,1}_w_valid/ready/data/strb/last  in/out/in/in/in  1/1/DATA_W/DATA_W/8/1  per-master write data.
- m{0,1}_r_valid/ready/data/id/resp/last  out/in/out/out/out/out  1/1/DATA_W/ID_W/2/1  per-master read response.
- m{0,1}_b_valid/ready/id/resp  out/in/out/out  1/1/ID_W/2  per-master write response.
- s_ar_*, s_aw_*, s_w_*  out (ready in)  same fields  slave-side request; s_*_id is ID_W+1 = {master_idx, id}.
- s_r_*, s_b_*  in (ready out)  same fields  slave-side response; s_*_id is ID_W+1.

Behaviour:
- AR arbiter:
  - Combinational mux; zero added latency.
  - rr_ar pointer (1 bit) names the preferred master. When both are valid the preferred master wins; a lone valid master wins regardless of the pointer.
  - The winner is held stable while s_ar_valid && !s_ar_ready (grant register ar_lock). Once a request is presented it never switches masters.
  - On s_ar handshake: rr_ar <= ~winner, ar_lock clears.
  - Loser ready=0. s_ar_id = {winner, m_ar_id}.
- AW arbiter: identical rules (rr_aw, aw_lock), gated by the write FSM.
- Write FSM:
  - States W_IDLE, W_DATA0, W_DATA1.
  - AW is offered only in W_IDLE. On s_aw handshake move to W_DATA<winner>.
  - In W_DATAn, s_w_* mirrors mn_w_* and mn_w_ready = s_w_ready; the other master's w_ready = 0. Return to W_IDLE on a handshake with last=1.
  - W beats arriving before the AW grant are stalled (ready=0).
  - len=0 (single beat): exactly one W beat, then W_IDLE.
- Response steering:
  - R: s_r_id[ID_W] selects the master. m_r_id = s_r_id[ID_W-1:0]; s_r_ready = selected m_r_ready. Unselected r_valid = 0. B is steered the same way.
  - R/B paths are pure combinational; responses for both masters may interleave freely.
- Reset values:
  - All valid/ready outputs 0; rr pointers 0 (master 0 preferred); locks cleared; FSM W_IDLE.
  - Reset mid-burst abandons the burst; there is no drain. The PS port is reset by the same domain.
- Simultaneous events: an AR handshake and an AW handshake in the same cycle update their pointers independently. A new AW can win in the same cycle the FSM returns to W_IDLE only from the next cycle onward; there is no same-cycle re-grant.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- When defined:
  - Adds outputs stat_rd_grants0/1 and stat_wr_grants0/1, each 32 bits.
  - Each counter increments on its master's s_ar/s_aw handshake and saturates at 0xFFFF_FFFF.
  - Adds input stat_clear, which zeroes all four counters synchronously; clear wins over a same-cycle increment. Counters reset to 0.
- When undefined: no counters, no ports, no logic.

Test Plan:
- Both masters assert AR at the same cycle after reset, m0 addr 0x100 id 3, m1 addr 0x200 id 3:
  - m0 is granted first with s_ar_id=0x03.
  - m1 is granted next with s_ar_id=0x23; each m_r gets only its own beats with id 3.
- Back-to-back AW from m1 only, with s_aw_ready stalled 4 cycles:
  - m1 addr is held stable on s_aw_* throughout the stall.
  - Lock prevents switching when m0 raises aw_valid mid-stall; m0 is granted after.
- m0 AW len=3 then m1 AW immediately:
  - m1 AW is not accepted until m0's 4th W beat (last=1) completes.
  - m1 W beats are stalled meanwhile.
- Interleaved slave responses, R ids 0x21, 0x01, 0x22 with rlast each:
  - Delivered to m1, m0, m1 with ids 1, 1, 2.
  - Back-pressure on m0_r_ready stalls s_r_ready only while the R id selects m0.
- Synchronous reset asserted mid-way through a 4-beat write in W_DATA1:
  - Next cycle all outputs valid/ready=0 and the FSM is W_IDLE.
  - A fresh m0 AW is then granted first.
- With MEM_ARB_STATS_EN: 5 m0 reads and 2 m1 writes give stat_rd_grants0=5 and stat_wr_grants1=2. stat_clear pulse gives all counters 0 the next cycle.
